muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers for the EX stage.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_unit_step.sv | 38 +++
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared operation codes and FSM state encoding for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_RUN  = 2'd1,
        MDS_FIX  = 2'd2
    } mds_state_e;

endpackage

// File: rtl/muldiv_unit_step.sv
// One radix-2 iteration on the {acc,q} pair: shift-add multiply or restoring divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // NOTE: every output of a combinational block is assigned on every path, otherwise a latch is inferred.
    always_comb begin
        sum    = {1'b0, acc_in} + {1'b0, b};
        rem_sh = {acc_in, q_in[WIDTH-1]};
        diff   = rem_sh - {1'b0, b};
        if (is_div) begin
            // A clear sign bit means the trial subtraction fits: keep it and shift in a quotient 1.
            if (!diff[WIDTH]) begin
                acc_out = diff[WIDTH-1:0];
                q_out   = {q_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = rem_sh[WIDTH-1:0];
                q_out   = {q_in[WIDTH-2:0], 1'b0};
            end
        end else if (q_in[0]) begin
            {acc_out, q_out} = {sum, q_in[WIDTH-1:1]};
        end else begin
            {acc_out, q_out} = {1'b0, acc_in, q_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MULDIV_FAST_MULT_EN for single-cycle combinational MULT/MULTU.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mds_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, b_q, b_d, a_raw_q, a_raw_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d, neg_main_q, neg_main_d, neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d, done_q, done_d;

    logic             op_signed, op_is_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs, step_acc, step_q, quo, rem;
    logic [2*WIDTH-1:0] prod_mag, prod;

    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign op_is_div = (op == MD_DIV)  || (op == MD_DIVU);
    assign a_neg     = op_signed & rs_val[WIDTH-1];
    assign b_neg     = op_signed & rt_val[WIDTH-1];
    assign a_abs     = a_neg ? -rs_val : rs_val;
    assign b_abs     = b_neg ? -rt_val : rt_val;

    // Sign fixup of the finished magnitudes; MIN/-1 wraps back to MIN naturally.
    assign prod_mag = {acc_q, q_q};
    assign prod     = neg_main_q ? -prod_mag : prod_mag;
    assign quo      = neg_main_q ? -q_q : q_q;
    assign rem      = neg_rem_q ? -acc_q : acc_q;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_mag, fast_prod;
    assign fast_mag  = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
    assign fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_q),
        .acc_in  (acc_q),
        .q_in    (q_q),
        .b       (b_q),
        .acc_out (step_acc),
        .q_out   (step_q)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        q_d        = q_q;
        b_d        = b_q;
        a_raw_d    = a_raw_q;
        is_div_d   = is_div_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        div0_d     = div0_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        unique case (state_q)
            MDS_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            // Divide iterates on the dividend; multiply iterates on the multiplier.
                            is_div_d   = op_is_div;
                            neg_main_d = a_neg ^ b_neg;
                            neg_rem_d  = a_neg;
                            div0_d     = op_is_div && (rt_val == '0);
                            a_raw_d    = rs_val;
                            acc_d      = '0;
                            q_d        = op_is_div ? a_abs : b_abs;
                            b_d        = op_is_div ? b_abs : a_abs;
                            cnt_d      = CW'(WIDTH - 1);
                            state_d    = MDS_RUN;
`ifdef MULDIV_FAST_MULT_EN
                            if (!op_is_div) begin
                                {hi_d, lo_d} = fast_prod;
                                done_d       = 1'b1;
                                state_d      = MDS_IDLE;
                            end
`endif
                        end
                        MD_MTHI: hi_d = rs_val;
                        MD_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            MDS_RUN: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = MDS_FIX;
                end
            end
            MDS_FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (div0_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                done_d  = 1'b1;
                state_d = MDS_IDLE;
            end
            default: state_d = MDS_IDLE;
        endcase

        // A kill overrides everything above, including a start in the same cycle.
        if (flush) begin
            state_d = MDS_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= MDS_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            b_q        <= '0;
            a_raw_q    <= '0;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            b_q        <= b_d;
            a_raw_q    <= a_raw_d;
            is_div_q   <= is_div_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            div0_q     <= div0_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q != MDS_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issued ops push expected HI/LO, a monitor pops on done.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [2:0]   op;
    logic [W-1:0] rs_val, rt_val, hi, lo;
    logic         busy, done;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           issue_cyc;
        int           lat;
        string        tag;
    } exp_t;

    exp_t         scoreboard[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on 64-bit integers, independent of any iteration scheme.
    function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] rh, output logic [W-1:0] rl);
        longint     sa, sbv, p;
        logic [63:0] up;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        rh  = '0;
        rl  = '0;
        case (o)
            MD_MULT:  begin p = sa * sbv; {rh, rl} = p; end
            MD_MULTU: begin up = {32'b0, a} * {32'b0, b}; {rh, rl} = up; end
            MD_DIV:   if (b == 0) begin rl = '1; rh = a; end
                      else begin rl = 32'(sa / sbv); rh = 32'(sa % sbv); end
            MD_DIVU:  if (b == 0) begin rl = '1; rh = a; end
                      else begin rl = a / b; rh = a % b; end
            default: ;
        endcase
    endfunction

    function automatic int expected_latency(input logic [2:0] o);
`ifdef MULDIV_FAST_MULT_EN
        if (o == MD_MULT || o == MD_MULTU) return 0;
`endif
        return W + 1 + 0 * o;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                check("done_not_back_to_back", 64'(prev_done), 64'd0);
                if (scoreboard.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = scoreboard.pop_front();
                    check({e.tag, " hi"}, 64'(hi), 64'(e.hi));
                    check({e.tag, " lo"}, 64'(lo), 64'(e.lo));
                    check({e.tag, " latency"}, 64'(cyc - e.issue_cyc), 64'(e.lat));
                end
            end
            prev_done = reset ? 1'b0 : done;
        end
    end

    // Called and returns at #1 after a rising edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
        int           guard;
        logic [W-1:0] rh, rl;
        exp_t         e;
        guard = 0;
        while (busy && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy) check("issue_wait_timeout", 64'(busy), 64'd0);
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (track) begin
            if (o <= 3'd3) begin
                ref_model(o, a, b, rh, rl);
                e.hi        = rh;
                e.lo        = rl;
                e.issue_cyc = cyc;
                e.lat       = expected_latency(o);
                e.tag       = $sformatf("op%0d 0x%0h,0x%0h", o, a, b);
                scoreboard.push_back(e);
                model_hi = rh;
                model_lo = rl;
            end else if (o == MD_MTHI) begin
                model_hi = a;
            end else if (o == MD_MTLO) begin
                model_lo = a;
            end
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((busy || done) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy) check("drain_timeout", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return {1'b1, {(W-1){1'b0}}};
            2:       return '1;
            3:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        op     = '0;
        rs_val = '0;
        rt_val = '0;
        #12;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed corner cases.
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(MD_MULT, -32'sd7, 32'd3, 1'b1);
        issue(MD_DIV, -32'sd7, 32'd2, 1'b1);
        check("busy after div start", 64'(busy), 64'd1);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(MD_DIVU, 32'd100, 32'd0, 1'b1);
        issue(MD_DIV, -32'sd5, 32'd0, 1'b1);
        issue(MD_DIV, 32'd7, -32'sd2, 1'b1);
        drain();

        // MTHI then MTLO in consecutive cycles.
        issue(MD_MTHI, 32'h1234, 32'd0, 1'b1);
        check("mthi busy", 64'(busy), 64'd0);
        issue(MD_MTLO, 32'h5678, 32'd0, 1'b1);
        check("mt hi", 64'(hi), 64'h1234);
        check("mt lo", 64'(lo), 64'h5678);
        check("mt busy", 64'(busy), 64'd0);

        // Flush mid-divide.
        issue(MD_DIVU, 32'd1000, 32'd7, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush hi", 64'(hi), 64'(model_hi));
        check("flush lo", 64'(lo), 64'(model_lo));
        repeat (W + 5) begin @(posedge clk); #1; end

        // Flush while in the fixup cycle suppresses the write.
        issue(MD_DIVU, 32'd55, 32'd5, 1'b0);
        repeat (W) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fix flush busy", 64'(busy), 64'd0);
        check("fix flush hi", 64'(hi), 64'(model_hi));
        check("fix flush lo", 64'(lo), 64'(model_lo));
        repeat (4) begin @(posedge clk); #1; end

        // Flush and start together: start is dropped.
        op = MD_MTHI; rs_val = 32'hDEAD; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush+start hi", 64'(hi), 64'(model_hi));

        // Reserved op code is ignored.
        issue(3'd6, 32'hAAAA, 32'hBBBB, 1'b0);
        check("op6 hi", 64'(hi), 64'(model_hi));
        check("op6 busy", 64'(busy), 64'd0);

        // Start while busy is ignored; only one done results.
        issue(MD_MULTU, 32'd6, 32'd7, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        op = MD_DIVU; rs_val = 32'd9; rt_val = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();

        // Randomised back-to-back traffic.
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'b1);
        end
        drain();
        check("random hi settled", 64'(hi), 64'(model_hi));
        check("random lo settled", 64'(lo), 64'(model_lo));

        // Reset mid-divide.
        issue(MD_DIV, 32'd12345, 32'd17, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 4) begin @(posedge clk); #1; end

        check("scoreboard drained", 64'(scoreboard.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
